// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shift unit: operation modes and FSM states.
package shift_pkg;

  localparam logic [2:0] SH_LSR = 3'b000;
  localparam logic [2:0] SH_LSL = 3'b001;
  localparam logic [2:0] SH_ASR = 3'b010;
  localparam logic [2:0] SH_ROR = 3'b011;
  localparam logic [2:0] SH_ROL = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic mode_reserved(input logic [2:0] m);
    return m > SH_ROL;
  endfunction

endpackage

// File: rtl/shift_unit_seq_if.sv
// Request/response bundle of the shift unit: operand request in, flagged result out.
interface shift_unit_seq_if #(
  parameter int Width = 16
);
  localparam int AW = $clog2(Width);

  logic             In_Valid;
  logic             In_Ready;
  logic [Width-1:0] A;
  logic [Width-1:0] B;
  logic             Src_Sel;
  logic [2:0]       Mode;
  logic [AW-1:0]    Shift_Amt;
  logic             Out_Valid;
  logic             Out_Ready;
  logic [Width-1:0] Shift_OUT;
  logic             Carry_Flag;
  logic             Zero_Flag;

  modport master (
    output In_Valid, A, B, Src_Sel, Mode, Shift_Amt, Out_Ready,
    input  In_Ready, Out_Valid, Shift_OUT, Carry_Flag, Zero_Flag
  );

  modport slave (
    input  In_Valid, A, B, Src_Sel, Mode, Shift_Amt, Out_Ready,
    output In_Ready, Out_Valid, Shift_OUT, Carry_Flag, Zero_Flag
  );

endinterface

// File: rtl/shift_step.sv
// One combinational shift of up to Step bits; also reports the last bit shifted/rotated out.
module shift_step
  import shift_pkg::*;
#(
  parameter  int Width = 16,
  parameter  int Step  = 1,
  localparam int CW    = $clog2(Step) + 1
) (
  input  logic [Width-1:0] val_i,
  input  logic [2:0]       mode_i,
  input  logic [CW-1:0]    chunk_i,
  output logic [Width-1:0] val_o,
  output logic             last_o
);

  logic        [Width:0]   rgt;
  logic        [Width:0]   lft;
  logic signed [Width-1:0] sval;

  // Guard bit below/above the operand catches the last bit out; it is 0 for a zero chunk.
  assign rgt  = {val_i, 1'b0} >> chunk_i;
  assign lft  = {1'b0, val_i} << chunk_i;
  assign sval = val_i;

  always_comb begin
    val_o  = val_i;
    last_o = 1'b0;
    case (mode_i)
      SH_LSR: begin
        val_o  = rgt[Width:1];
        last_o = rgt[0];
      end
      SH_ASR: begin
        val_o  = sval >>> chunk_i;
        last_o = rgt[0];
      end
      SH_ROR: begin
        val_o  = (val_i >> chunk_i) | (val_i << (Width - int'(chunk_i)));
        last_o = rgt[0];
      end
      SH_LSL: begin
        val_o  = lft[Width-1:0];
        last_o = lft[Width];
      end
      SH_ROL: begin
        val_o  = (val_i << chunk_i) | (val_i >> (Width - int'(chunk_i)));
        last_o = lft[Width];
      end
      default: begin
        val_o  = val_i;
        last_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_unit_seq.sv
// Multi-cycle shift unit: accepts a request, shifts up to Step bits per clock,
// then holds the result and flags until the consumer takes it.
module shift_unit_seq
  import shift_pkg::*;
#(
  parameter int Width = 16,
  parameter int Step  = 1
) (
  input logic             CLK,
  input logic             RST,
  shift_unit_seq_if.slave bus
);

  localparam int AW = $clog2(Width);
  localparam int RW = AW + 1;
  localparam int CW = $clog2(Step) + 1;

  state_t           state_q, state_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic [Width-1:0] work_q, work_d;
  logic [2:0]       mode_q, mode_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;

  logic [CW-1:0]    chunk;
  logic [Width-1:0] step_val;
  logic             step_last;
  logic [Width-1:0] operand;

  assign chunk   = (rem_q > RW'(Step)) ? CW'(Step) : CW'(rem_q);
  assign operand = bus.Src_Sel ? bus.B : bus.A;

  shift_step #(
    .Width (Width),
    .Step  (Step)
  ) u_step (
    .val_i   (work_q),
    .mode_i  (mode_q),
    .chunk_i (chunk),
    .val_o   (step_val),
    .last_o  (step_last)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    work_d  = work_q;
    mode_d  = mode_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.In_Valid) begin
          work_d  = operand;
          mode_d  = bus.Mode;
          carry_d = 1'b0;
          // Zero distance and reserved modes skip the shifter and present the operand as-is.
          if (bus.Shift_Amt == '0 || mode_reserved(bus.Mode)) begin
            rem_d   = '0;
            zero_d  = (operand == '0);
            state_d = ST_DONE;
          end else begin
            rem_d   = RW'(bus.Shift_Amt);
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        work_d  = step_val;
        carry_d = step_last;
        rem_d   = rem_q - RW'(chunk);
        if (rem_d == '0) begin
          zero_d  = (step_val == '0);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.Out_Ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      work_q  <= '0;
      mode_q  <= SH_LSR;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      work_q  <= work_d;
      mode_q  <= mode_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.In_Ready   = (state_q == ST_IDLE);
  assign bus.Out_Valid  = (state_q == ST_DONE);
  assign bus.Shift_OUT  = work_q;
  assign bus.Carry_Flag = carry_q;
  assign bus.Zero_Flag  = zero_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed bench for shift_unit_seq: one instance with Step=1 and one with Step=4.
module tb_shift_unit_seq;
  import shift_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  int   pass_cnt = 0;
  int   fail_cnt = 0;

  shift_unit_seq_if #(.Width(16)) if1 ();
  shift_unit_seq_if #(.Width(16)) if4 ();

  shift_unit_seq #(.Width(16), .Step(1)) u1 (.CLK(CLK), .RST(RST), .bus(if1));
  shift_unit_seq #(.Width(16), .Step(4)) u4 (.CLK(CLK), .RST(RST), .bus(if4));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit s4, input bit v, input bit src, input logic [15:0] a,
                       input logic [15:0] b, input logic [2:0] m, input logic [3:0] amt);
    if (s4) begin
      if4.In_Valid = v; if4.Src_Sel = src; if4.A = a; if4.B = b; if4.Mode = m; if4.Shift_Amt = amt;
    end else begin
      if1.In_Valid = v; if1.Src_Sel = src; if1.A = a; if1.B = b; if1.Mode = m; if1.Shift_Amt = amt;
    end
  endtask

  task automatic set_ordy(input bit s4, input bit r);
    if (s4) if4.Out_Ready = r;
    else    if1.Out_Ready = r;
  endtask

  task automatic get(input bit s4, output logic rdy, output logic ov, output logic [15:0] out,
                     output logic c, output logic z);
    if (s4) begin
      rdy = if4.In_Ready; ov = if4.Out_Valid; out = if4.Shift_OUT; c = if4.Carry_Flag; z = if4.Zero_Flag;
    end else begin
      rdy = if1.In_Ready; ov = if1.Out_Valid; out = if1.Shift_OUT; c = if1.Carry_Flag; z = if1.Zero_Flag;
    end
  endtask

  // Caller is at a negedge; request is presented for exactly one rising edge.
  task automatic issue(input bit s4, input bit src, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] m, input logic [3:0] amt);
    drive(s4, 1'b1, src, a, b, m, amt);
    @(posedge CLK);
    #1 drive(s4, 1'b0, src, a, b, m, amt);
  endtask

  task automatic wait_valid(input bit s4, input int lat_exp, input string tag);
    logic rdy, ov, c, z;
    logic [15:0] out;
    int lat = 0;
    @(negedge CLK);
    get(s4, rdy, ov, out, c, z);
    while (!ov && lat < 40) begin
      @(negedge CLK);
      lat++;
      get(s4, rdy, ov, out, c, z);
    end
    chk({tag, "_lat"}, 32'(lat), 32'(lat_exp));
  endtask

  task automatic check_result(input bit s4, input logic [15:0] out_exp, input logic c_exp,
                              input logic z_exp, input string tag);
    logic rdy, ov, c, z;
    logic [15:0] out;
    get(s4, rdy, ov, out, c, z);
    chk({tag, "_out"},   32'(out), 32'(out_exp));
    chk({tag, "_carry"}, 32'(c),   32'(c_exp));
    chk({tag, "_zero"},  32'(z),   32'(z_exp));
    chk({tag, "_irdy"},  32'(rdy), 32'(0));
  endtask

  task automatic release_out(input bit s4, input string tag);
    logic rdy, ov, c, z;
    logic [15:0] out;
    set_ordy(s4, 1'b1);
    @(posedge CLK);
    #1 set_ordy(s4, 1'b0);
    @(negedge CLK);
    get(s4, rdy, ov, out, c, z);
    chk({tag, "_ov_after"},   32'(ov),  32'(0));
    chk({tag, "_irdy_after"}, 32'(rdy), 32'(1));
  endtask

  task automatic run(input bit s4, input bit src, input logic [15:0] a, input logic [15:0] b,
                     input logic [2:0] m, input logic [3:0] amt, input int lat_exp,
                     input logic [15:0] out_exp, input logic c_exp, input logic z_exp,
                     input string tag);
    @(negedge CLK);
    issue(s4, src, a, b, m, amt);
    wait_valid(s4, lat_exp, tag);
    check_result(s4, out_exp, c_exp, z_exp, tag);
    release_out(s4, tag);
  endtask

  initial begin
    logic rdy, ov, c, z;
    logic [15:0] out;
    bit stale;

    RST = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, SH_LSR, 4'd0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, SH_LSR, 4'd0);
    set_ordy(1'b0, 1'b0);
    set_ordy(1'b1, 1'b0);
    repeat (2) @(negedge CLK);
    get(1'b0, rdy, ov, out, c, z);
    chk("rst_ov",    32'(ov),  32'(0));
    chk("rst_out",   32'(out), 32'(0));
    chk("rst_carry", 32'(c),   32'(0));
    chk("rst_zero",  32'(z),   32'(0));
    RST = 1'b0;
    @(negedge CLK);
    get(1'b0, rdy, ov, out, c, z);
    chk("rel_irdy1", 32'(rdy), 32'(1));
    get(1'b1, rdy, ov, out, c, z);
    chk("rel_irdy4", 32'(rdy), 32'(1));
    chk("rel_ov4",   32'(ov),  32'(0));

    // Step = 1
    run(1'b0, 1'b0, 16'h8001, 16'hFFFF, SH_LSR, 4'd1, 1, 16'h4000, 1'b1, 1'b0, "lsr1");
    run(1'b0, 1'b1, 16'h1111, 16'h8000, SH_ASR, 4'd3, 3, 16'hF000, 1'b0, 1'b0, "asr3");
    run(1'b0, 1'b0, 16'hABCD, 16'h0000, SH_LSL, 4'd0, 0, 16'hABCD, 1'b0, 1'b0, "amt0");

    // Step = 4
    run(1'b1, 1'b0, 16'h1234, 16'h0000, SH_ROL, 4'd8,  2, 16'h3412, 1'b0, 1'b0, "rol8");
    run(1'b1, 1'b0, 16'h1234, 16'h0000, SH_LSL, 4'd15, 4, 16'h0000, 1'b0, 1'b1, "lsl15");
    run(1'b1, 1'b0, 16'h1234, 16'h0000, SH_LSR, 4'd5,  2, 16'h0091, 1'b1, 1'b0, "lsr5");
    run(1'b1, 1'b0, 16'h1234, 16'h0000, SH_ROR, 4'd3,  1, 16'h8246, 1'b1, 1'b0, "ror3");
    run(1'b1, 1'b0, 16'hABCD, 16'h0000, 3'b111, 4'd5,  0, 16'hABCD, 1'b0, 1'b0, "rsvd");

    // Back-pressure: result must hold and a new request must be ignored.
    @(negedge CLK);
    issue(1'b0, 1'b0, 16'h00F0, 16'h0000, SH_LSR, 4'd5);
    wait_valid(1'b0, 5, "bp");
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (cyc == 1) drive(1'b0, 1'b1, 1'b1, 16'h0000, 16'hFFFF, SH_LSL, 4'd3);
      if (cyc == 3) drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, SH_LSR, 4'd0);
      get(1'b0, rdy, ov, out, c, z);
      chk($sformatf("bp_ov_c%0d", cyc),    32'(ov),  32'(1));
      chk($sformatf("bp_out_c%0d", cyc),   32'(out), 32'(16'h0007));
      chk($sformatf("bp_carry_c%0d", cyc), 32'(c),   32'(1));
      chk($sformatf("bp_zero_c%0d", cyc),  32'(z),   32'(0));
      chk($sformatf("bp_irdy_c%0d", cyc),  32'(rdy), 32'(0));
      @(negedge CLK);
    end
    release_out(1'b0, "bp");
    issue(1'b0, 1'b0, 16'h0000, 16'h5555, SH_LSL, 4'd0);
    wait_valid(1'b0, 0, "b2b");
    check_result(1'b0, 16'h0000, 1'b0, 1'b1, "b2b");
    release_out(1'b0, "b2b");

    // Reset in the middle of a shift.
    @(negedge CLK);
    issue(1'b0, 1'b0, 16'hFFFF, 16'h0000, SH_LSL, 4'd10);
    repeat (4) @(negedge CLK);
    RST = 1'b1;
    #1 get(1'b0, rdy, ov, out, c, z);
    chk("mrst_ov",    32'(ov),  32'(0));
    chk("mrst_out",   32'(out), 32'(0));
    chk("mrst_carry", 32'(c),   32'(0));
    chk("mrst_irdy",  32'(rdy), 32'(1));
    @(negedge CLK);
    RST = 1'b0;
    stale = 1'b0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(negedge CLK);
      get(1'b0, rdy, ov, out, c, z);
      if (ov) stale = 1'b1;
    end
    chk("mrst_stale", 32'(stale), 32'(0));
    chk("mrst_irdy_rel", 32'(rdy), 32'(1));
    run(1'b0, 1'b0, 16'h8001, 16'h0000, SH_LSL, 4'd1, 1, 16'h0002, 1'b1, 1'b0, "recov");

    $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
    $finish;
  end

endmodule
